// File: rtl/segment_merger.sv
// segment_merger
//   Merges NUM_SEG parallel pixel-generator segment streams into one line-ordered
//   pixel stream: for every line, seg 0 supplies SEG_BEATS beats, then seg 1, and
//   so on; LINES lines make a frame. Internal counters decide line/frame framing;
//   input tlast/tuser are only checked against them (sticky err flags).
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   in_t*           : per-segment AXI-Stream slices (segment k at [32k+31:32k] etc.)
//   in_tready       : per-segment ready, only the segment in turn is ever ready
//   out_t*          : merged stream from a single output register
//   err             : sticky; bit0 input tlast mismatch, bit1 misplaced input tuser
//   frame_done      : pulse when the last beat of a frame is taken downstream
module segment_merger #(
  parameter int NUM_SEG   = 4,
  parameter int SEG_BEATS = 160,
  parameter int LINES     = 480
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SEG*32-1:0]  in_tdata,
  input  logic [NUM_SEG*4-1:0]   in_tkeep,
  input  logic [NUM_SEG-1:0]     in_tlast,
  input  logic [NUM_SEG-1:0]     in_tuser,
  input  logic [NUM_SEG-1:0]     in_tvalid,
  output logic [NUM_SEG-1:0]     in_tready,
  output logic [31:0]            out_tdata,
  output logic [3:0]             out_tkeep,
  output logic                   out_tlast,
  output logic                   out_tuser,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [1:0]             err,
  output logic                   frame_done
);

  localparam int SEG_W  = (NUM_SEG   > 1) ? $clog2(NUM_SEG)   : 1;
  localparam int BEAT_W = (SEG_BEATS > 1) ? $clog2(SEG_BEATS) : 1;
  localparam int LINE_W = (LINES     > 1) ? $clog2(LINES)     : 1;

  typedef enum logic {SYNC, STREAM} state_t;

  state_t              state_q, state_d;
  logic [SEG_W-1:0]    seg_sel_q, seg_sel_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
  logic [31:0]         out_tdata_q, out_tdata_d;
  logic [3:0]          out_tkeep_q, out_tkeep_d;
  logic                out_tlast_q, out_tlast_d;
  logic                out_tuser_q, out_tuser_d;
  logic                out_tvalid_q, out_tvalid_d;
  logic                out_eof_q, out_eof_d;   // buffered beat ends the frame
  logic [1:0]          err_q, err_d;

  logic                out_free;
  logic                sel_valid, sel_last, sel_user;
  logic [31:0]         sel_data;
  logic [3:0]          sel_keep;
  logic                fwd;
  logic                seg_last, beat_last, line_last, first_pos;

  always_comb begin
    state_d      = state_q;
    seg_sel_d    = seg_sel_q;
    beat_cnt_d   = beat_cnt_q;
    line_cnt_d   = line_cnt_q;
    out_tdata_d  = out_tdata_q;
    out_tkeep_d  = out_tkeep_q;
    out_tlast_d  = out_tlast_q;
    out_tuser_d  = out_tuser_q;
    out_tvalid_d = out_tvalid_q;
    out_eof_d    = out_eof_q;
    err_d        = err_q;
    in_tready    = '0;
    sel_valid    = 1'b0;
    sel_last     = 1'b0;
    sel_user     = 1'b0;
    sel_data     = '0;
    sel_keep     = '0;

    out_free  = !out_tvalid_q || out_tready;
    seg_last  = (seg_sel_q  == SEG_W'(NUM_SEG - 1));
    beat_last = (beat_cnt_q == BEAT_W'(SEG_BEATS - 1));
    line_last = (line_cnt_q == LINE_W'(LINES - 1));
    first_pos = (seg_sel_q == '0) && (beat_cnt_q == '0) && (line_cnt_q == '0);

    // seg_sel stays 0 throughout SYNC, so the same selection serves both states.
    // In SYNC the seg-0 ready is also held off while a finished frame's last beat
    // still sits stalled in the output register, so a new sof beat is never lost.
    for (int unsigned k = 0; k < NUM_SEG; k++) begin
      if (SEG_W'(k) == seg_sel_q) begin
        in_tready[k] = out_free && !reset;
        sel_valid    = in_tvalid[k];
        sel_last     = in_tlast[k];
        sel_user     = in_tuser[k];
        sel_data     = in_tdata[k*32 +: 32];
        sel_keep     = in_tkeep[k*4 +: 4];
      end
    end

    fwd = sel_valid && out_free && !reset && ((state_q == STREAM) || sel_user);

    if (out_tready) out_tvalid_d = 1'b0;

    if (fwd) begin
      out_tvalid_d = 1'b1;
      out_tdata_d  = sel_data;
      out_tkeep_d  = sel_keep;
      out_tlast_d  = seg_last && beat_last;
      out_tuser_d  = (state_q == SYNC);
      out_eof_d    = seg_last && beat_last && line_last;

      if (sel_last != beat_last) err_d[0] = 1'b1;
      if ((state_q == STREAM) && (seg_sel_q == '0) && sel_user && !first_pos)
        err_d[1] = 1'b1;

      state_d    = STREAM;
      beat_cnt_d = beat_cnt_q + 1'b1;
      if (beat_last) begin
        beat_cnt_d = '0;
        seg_sel_d  = seg_sel_q + 1'b1;
        if (seg_last) begin
          seg_sel_d  = '0;
          line_cnt_d = line_cnt_q + 1'b1;
          if (line_last) begin
            line_cnt_d = '0;
            state_d    = SYNC;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SYNC;
      seg_sel_q    <= '0;
      beat_cnt_q   <= '0;
      line_cnt_q   <= '0;
      out_tdata_q  <= '0;
      out_tkeep_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_tuser_q  <= 1'b0;
      out_tvalid_q <= 1'b0;
      out_eof_q    <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      seg_sel_q    <= seg_sel_d;
      beat_cnt_q   <= beat_cnt_d;
      line_cnt_q   <= line_cnt_d;
      out_tdata_q  <= out_tdata_d;
      out_tkeep_q  <= out_tkeep_d;
      out_tlast_q  <= out_tlast_d;
      out_tuser_q  <= out_tuser_d;
      out_tvalid_q <= out_tvalid_d;
      out_eof_q    <= out_eof_d;
      err_q        <= err_d;
    end
  end

  assign out_tdata  = out_tdata_q;
  assign out_tkeep  = out_tkeep_q;
  assign out_tlast  = out_tlast_q;
  assign out_tuser  = out_tuser_q;
  assign out_tvalid = out_tvalid_q;
  assign err        = err_q;
  assign frame_done = out_tvalid_q && out_tready && out_eof_q && !reset;

endmodule

// File: tb/tb_segment_merger.sv
// tb_segment_merger
//   Scoreboard bench for segment_merger with NUM_SEG=2, SEG_BEATS=3, LINES=2.
//   Per-segment source queues feed the inputs; the expected merged beats are
//   pushed when a frame is loaded and popped as the DUT hands beats downstream.
module tb_segment_merger;

  localparam int NUM_SEG   = 2;
  localparam int SEG_BEATS = 3;
  localparam int LINES     = 2;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
    logic        fd;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_SEG*32-1:0] in_tdata = '0;
  logic [NUM_SEG*4-1:0]  in_tkeep = '0;
  logic [NUM_SEG-1:0]    in_tlast = '0;
  logic [NUM_SEG-1:0]    in_tuser = '0;
  logic [NUM_SEG-1:0]    in_tvalid = '0;
  logic [NUM_SEG-1:0]    in_tready;
  logic [31:0]           out_tdata;
  logic [3:0]            out_tkeep;
  logic                  out_tlast;
  logic                  out_tuser;
  logic                  out_tvalid;
  logic                  out_tready = 1'b1;
  logic [1:0]            err;
  logic                  frame_done;

  beat_t seg_q[NUM_SEG][$];
  exp_t  exp_q[$];
  int    pop_cycles[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  bit    rand_ready = 1'b0;

  always #5 clk = ~clk;

  segment_merger #(
    .NUM_SEG  (NUM_SEG),
    .SEG_BEATS(SEG_BEATS),
    .LINES    (LINES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_tdata  (in_tdata),
    .in_tkeep  (in_tkeep),
    .in_tlast  (in_tlast),
    .in_tuser  (in_tuser),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .out_tdata (out_tdata),
    .out_tkeep (out_tkeep),
    .out_tlast (out_tlast),
    .out_tuser (out_tuser),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .err       (err),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue one frame on the segment sources and its expected output beats.
  task automatic load_frame(input int junk, input bit bad_tlast, input bit bad_tuser);
    beat_t b;
    exp_t  e;
    for (int j = 0; j < junk; j++) begin
      b.data = 32'hEE00 + 32'(j);
      b.keep = 4'h5;
      b.last = 1'b0;
      b.user = 1'b0;
      seg_q[0].push_back(b);
    end
    for (int l = 0; l < LINES; l++) begin
      for (int s = 0; s < NUM_SEG; s++) begin
        for (int t = 0; t < SEG_BEATS; t++) begin
          b.data = 32'(s * 16 + t);
          b.keep = 4'hF ^ 4'(t);
          b.last = (t == SEG_BEATS - 1);
          b.user = (l == 0 && s == 0 && t == 0);
          if (bad_tlast && l == 0 && s == 1 && t == 1) b.last = 1'b1;
          if (bad_tuser && l == 1 && s == 0 && t == 0) b.user = 1'b1;
          seg_q[s].push_back(b);
          e.data = b.data;
          e.keep = b.keep;
          e.last = (s == NUM_SEG - 1) && (t == SEG_BEATS - 1);
          e.user = (l == 0 && s == 0 && t == 0);
          e.fd   = e.last && (l == LINES - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  function automatic bit sources_empty();
    for (int k = 0; k < NUM_SEG; k++)
      if (seg_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || !sources_empty()) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Source driver: handshakes seen at the negedge are retired after the edge.
  logic [NUM_SEG-1:0] fire;
  always begin
    @(negedge clk);
    fire = in_tvalid & in_tready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_SEG; k++) begin
      if (fire[k] && seg_q[k].size() != 0) void'(seg_q[k].pop_front());
      if (seg_q[k].size() != 0) begin
        in_tvalid[k]         = 1'b1;
        in_tdata[k*32 +: 32] = seg_q[k][0].data;
        in_tkeep[k*4 +: 4]   = seg_q[k][0].keep;
        in_tlast[k]          = seg_q[k][0].last;
        in_tuser[k]          = seg_q[k][0].user;
      end else begin
        in_tvalid[k]         = 1'b0;
        in_tdata[k*32 +: 32] = '0;
        in_tkeep[k*4 +: 4]   = '0;
        in_tlast[k]          = 1'b0;
        in_tuser[k]          = 1'b0;
      end
    end
    out_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor / scoreboard.
  bit          stalled_prev = 1'b0;
  logic [39:0] held;
  always @(negedge clk) begin
    exp_t e;
    bit   hs;
    cyc++;
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      hs = out_tvalid && out_tready;
      if (stalled_prev)
        check("stall_hold", 64'({out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser}),
              64'({1'b1, held[37:0]}));
      if (hs) begin
        pop_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(out_tdata), 64'hFFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_tdata", 64'(out_tdata), 64'(e.data));
          check("out_tkeep", 64'(out_tkeep), 64'(e.keep));
          check("out_tlast", 64'(out_tlast), 64'(e.last));
          check("out_tuser", 64'(out_tuser), 64'(e.user));
          check("frame_done", 64'(frame_done), 64'(e.fd));
        end
      end else begin
        check("frame_done_idle", 64'(frame_done), 64'd0);
      end
      stalled_prev = out_tvalid && !out_tready;
      held = {2'b0, out_tdata, out_tkeep, out_tlast, out_tuser};
    end
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    check("rst_out_tdata", 64'(out_tdata), 64'd0);
    check("rst_out_side", 64'({out_tkeep, out_tlast, out_tuser}), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_in_tready", 64'(in_tready), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    @(posedge clk); #2 reset = 1'b0;

    // Full-rate frame: 12 beats on 12 consecutive cycles.
    base = pop_cycles.size();
    load_frame(0, 1'b0, 1'b0);
    wait_drain("s1");
    check("s1_err", 64'(err), 64'd0);
    check("s1_beats", 64'(pop_cycles.size() - base), 64'd12);
    if (pop_cycles.size() - base == 12)
      check("s1_no_bubble", 64'(pop_cycles[base + 11] - pop_cycles[base]), 64'd11);

    // Seg-0 beats before sof are dropped.
    load_frame(3, 1'b0, 1'b0);
    wait_drain("s2");
    check("s2_err", 64'(err), 64'd0);

    // Random downstream stalls.
    rand_ready = 1'b1;
    load_frame(1, 1'b0, 1'b0);
    load_frame(0, 1'b0, 1'b0);
    wait_drain("s3");
    rand_ready = 1'b0;
    check("s3_err", 64'(err), 64'd0);

    // Early tlast on seg 1: flagged, framing unchanged.
    load_frame(0, 1'b1, 1'b0);
    wait_drain("s4");
    check("s4_err_tlast", 64'(err), 64'd1);

    // Reset mid-frame after 4 output beats.
    base = pop_cycles.size();
    load_frame(2, 1'b0, 1'b0);
    begin
      int t = 0;
      while (pop_cycles.size() - base < 4 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) check("s5_timeout", 64'(pop_cycles.size() - base), 64'd4);
    end
    @(posedge clk); #2;
    reset = 1'b1;
    for (int k = 0; k < NUM_SEG; k++) seg_q[k].delete();
    exp_q.delete();
    @(negedge clk);
    check("s5_rst_in_tready", 64'(in_tready), 64'd0);
    check("s5_rst_frame_done", 64'(frame_done), 64'd0);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    check("s5_out_tvalid", 64'(out_tvalid), 64'd0);
    check("s5_err", 64'(err), 64'd0);
    load_frame(1, 1'b0, 1'b0);
    wait_drain("s5");
    check("s5_err_after", 64'(err), 64'd0);

    // Stray sof on line 1.
    load_frame(0, 1'b0, 1'b1);
    wait_drain("s6");
    check("s6_err_tuser", 64'(err), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
